// File: rtl/modacc_stream.sv
// Streaming modular accumulator: sums each framed residue stream mod q = (qH << W) | 1.
// Optional MODACC_CNT_EN adds out_count, the beat count of each emitted frame.
module modacc_stream #(
  parameter int unsigned LOGQ  = 64,
  parameter int unsigned LOGQH = 47,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LOGQH-1:0] qH,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOGQ-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOGQ-1:0]  out_data
`ifdef MODACC_CNT_EN
  ,
  output logic [CNTW-1:0]  out_count
`endif
);

  localparam int unsigned W = LOGQ - LOGQH;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [LOGQ-1:0] acc;
  logic [CNTW-1:0] cnt;
  logic [LOGQ-1:0] q_lat;
  logic [LOGQ-1:0] q_live;
  logic [LOGQ-1:0] q_use;
  logic [LOGQ:0]   sum;
  logic [LOGQ:0]   diff;
  logic [LOGQ-1:0] red;
  logic            in_fire;
  logic            out_fire;
  logic            first;
  logic            close;

  // Modulus from its high part; a flat modulus when there is no low part.
  generate
    if (W == 0) begin : g_q_flat
      assign q_live = qH;
    end else begin : g_q_ntt
      assign q_live = (LOGQ'(qH) << W) | LOGQ'(1);
    end
  endgenerate

  assign out_valid = (state == ST_HOLD);
  assign in_ready  = ~out_valid | out_ready;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign first     = (cnt == '0);
  // A beat landing on a saturated counter closes the frame regardless of in_last.
  assign close     = in_last | (cnt == {CNTW{1'b1}});

  // One conditional subtraction; bit LOGQ of the difference is its sign.
  always_comb begin
    q_use = first ? q_live : q_lat;
    sum   = {1'b0, acc} + {1'b0, in_data};
    diff  = sum - {1'b0, q_use};
    red   = diff[LOGQ] ? sum[LOGQ-1:0] : diff[LOGQ-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // HOLD persists when a drained result is immediately replaced by a new one.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC:  if (in_fire && close) state_nxt = ST_HOLD;
      ST_HOLD: if (out_fire && !(in_fire && close)) state_nxt = ST_ACC;
      default: state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      q_lat    <= '0;
      out_data <= '0;
    end else if (in_fire) begin
      if (first) q_lat <= q_live;
      if (close) begin
        acc      <= '0;
        cnt      <= '0;
        out_data <= red;
      end else begin
        acc <= red;
        cnt <= cnt + CNTW'(1);
      end
    end
  end

`ifdef MODACC_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_count <= '0;
    end else if (in_fire && close) begin
      out_count <= cnt + CNTW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_modacc_stream.sv
// Directed and randomized bench for modacc_stream against a sum-mod-q reference model.
module tb_modacc_stream;

  localparam int unsigned LOGQ  = 8;
  localparam int unsigned LOGQH = 4;
  localparam int unsigned CNTW  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [LOGQH-1:0] qH;
  logic             in_valid;
  logic             in_ready;
  logic [LOGQ-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [LOGQ-1:0]  out_data;
`ifdef MODACC_CNT_EN
  logic [CNTW-1:0]  out_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [LOGQ-1:0] obs_q[$];
  int unsigned     exp_q[$];

  modacc_stream #(.LOGQ(LOGQ), .LOGQH(LOGQH), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .qH        (qH),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef MODACC_CNT_EN
    ,
    .out_count (out_count)
`endif
  );

  always #5 clk = ~clk;

  // Record every result that is handed downstream.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) obs_q.push_back(out_data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned qof(input int unsigned h);
    return (h * 16) + 1;
  endfunction

  function automatic int unsigned ref_sum(input int unsigned v[$], input int unsigned q);
    longint s = 0;
    foreach (v[i]) s += longint'(v[i]);
    return 32'(s % longint'(q));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int unsigned d, input bit last, input bit rnd);
    bit ok = 1'b0;
    int n  = 0;
    in_valid = 1'b1;
    in_data  = LOGQ'(d);
    in_last  = last;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      n++;
      if (!ok && rnd) out_ready = 1'($urandom_range(0, 1));
    end
    if (!ok) check("beat_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input int unsigned v[$]);
    foreach (v[i]) send_beat(v[i], (i == v.size() - 1), 1'b0);
  endtask

  task automatic expect_result(input string tag, input int unsigned exp, input int unsigned len,
                               input bit chk_cnt);
    @(negedge clk);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, 64'(out_data), 64'(exp));
`ifdef MODACC_CNT_EN
    if (chk_cnt) check({tag, "_count"}, 64'(out_count), 64'(CNTW'(len)));
`endif
    tick();
  endtask

  initial begin
    int unsigned v[$];
    int unsigned h;
    int unsigned len;

    rst = 1'b1; qH = 4'hF; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
`ifdef MODACC_CNT_EN
    check("rst_out_count", 64'(out_count), 64'd0);
`endif
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(in_ready), 64'd1);
    tick();

    // Single wrap
    v = '{200, 100};
    send_frame(v);
    expect_result("wrap", ref_sum(v, qof(15)), 2, 1'b1);
    @(negedge clk);
    check("wrap_drained", 64'(out_valid), 64'd0);
    tick();

    // Repeated wrap
    v = '{240, 240, 240};
    send_frame(v);
    expect_result("rewrap", ref_sum(v, qof(15)), 3, 1'b1);

    // Single-beat frame, then qH changed mid-frame
    v = '{5};
    send_frame(v);
    expect_result("single", 5, 1, 1'b1);
    send_beat(100, 1'b0, 1'b0);
    qH = 4'h7;
    send_beat(150, 1'b1, 1'b0);
    v = '{100, 150};
    expect_result("qlatch", ref_sum(v, qof(15)), 2, 1'b1);
    qH = 4'hF;
    tick();

    // Backpressure, then a back-to-back single-beat frame
    obs_q.delete();
    out_ready = 1'b0;
    v = '{120, 130};
    send_frame(v);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'(ref_sum(v, qof(15))));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'd7; in_last = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    expect_result("b2b", 7, 1, 1'b1);
    tick();
    check("bp_outputs", 64'(obs_q.size()), 64'd2);
    check("bp_first_out", 64'(obs_q[0]), 64'(ref_sum(v, qof(15))));

    // Reset in the middle of a frame
    obs_q.delete();
    send_beat(50, 1'b0, 1'b0);
    send_beat(60, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", 64'(out_valid), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    v = '{10};
    send_frame(v);
    expect_result("midrst", 10, 1, 1'b1);
    repeat (3) tick();
    check("midrst_outputs", 64'(obs_q.size()), 64'd1);
    check("midrst_out", 64'(obs_q[0]), 64'd10);

    // Counter saturation closes a frame that never asserts in_last
    v.delete();
    for (int i = 0; i < 16; i++) begin
      v.push_back(200);
      send_beat(200, 1'b0, 1'b0);
    end
    expect_result("overflow", ref_sum(v, qof(15)), 16, 1'b0);
    v = '{3};
    send_frame(v);
    expect_result("post_overflow", 3, 1, 1'b1);

    // Randomized frames with random moduli and random backpressure
    obs_q.delete();
    exp_q.delete();
    for (int f = 0; f < 25; f++) begin
      h   = $urandom_range(1, 15);
      len = $urandom_range(1, 5);
      qH  = LOGQH'(h);
      v.delete();
      for (int i = 0; i < int'(len); i++) v.push_back($urandom_range(0, qof(h) - 1));
      exp_q.push_back(ref_sum(v, qof(h)));
      foreach (v[i]) begin
        send_beat(v[i], (i == v.size() - 1), 1'b1);
        if (i == 0) qH = LOGQH'($urandom_range(0, 15));
      end
    end
    out_ready = 1'b1;
    repeat (4) tick();
    check("rand_outputs", 64'(obs_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) check($sformatf("rand_out%0d", i), 64'(obs_q[i]), 64'(exp_q[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
